instr_fetch_unit: RTL and testbench

//  - Fetch stage that consumes stall/stall_pm from stall_control and produces the instruction

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_pc_reg.sv | 38 +++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP word and FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OPCODE_HLT = 6'b010001;
    localparam logic [OPCODE_W-1:0] OPCODE_LD  = 6'b010100;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:INSTR_W-OPCODE_W];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: sync active-low reset, load (redirect) and hold enables, else +4 with wrap.
module instr_fetch_unit_pc_reg #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              hold_en_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: load beats hold, otherwise sequential advance.
    always_comb begin
        pc_d = pc_q + ADDR_W'(4);
        if (load_en_i) begin
            pc_d = load_val_i;
        end else if (hold_en_i) begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, handles jump redirect/squash and HLT.
// Optional feature macro FETCH_COUNT_EN adds a 32-bit fetched-word counter output.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_WORD = instr_fetch_unit_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              stall_pm,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       ir,
    output logic [5:0]        op,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ir_valid,
    output logic              halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    import instr_fetch_unit_pkg::*;

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pp4_q, pp4_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc;
    logic              hlt_seen;
    logic              run_go;
    logic              unused_tgt_bits;

    // HLT in a valid IR stops everything this cycle, including a pending jump.
    assign hlt_seen = (state_q == ST_RUN) && valid_q && (opcode_of(ir_q) == OPCODE_HLT);
    assign run_go   = (state_q == ST_RUN) && !hlt_seen;

    assign unused_tgt_bits = ^jump_target[1:0];

    instr_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n_i    (reset),
        .load_en_i  (run_go && jump_en),
        .load_val_i ({jump_target[ADDR_W-1:2], 2'b00}),
        .hold_en_i  (!run_go || stall),
        .pc_o       (pc)
    );

    // Next state and IR/link/valid update.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pp4_d   = pp4_q;
        valid_d = valid_q;
        if (hlt_seen) begin
            state_d = ST_HALT;
        end
        if (run_go && !stall_pm) begin
            if (jump_en) begin
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
            end else begin
                ir_d    = imem_rdata;
                pp4_d   = pc + ADDR_W'(4);
                valid_d = 1'b1;
            end
        end
    end

    // State and IR registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            ir_q    <= NOP_WORD;
            pp4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pp4_q   <= pp4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fc_q;
    logic        ir_load;

    assign ir_load = run_go && !stall_pm && !jump_en;

    // Counts every cycle IR captures a word from instruction memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fc_q <= '0;
        end else if (ir_load) begin
            fc_q <= fc_q + 32'(1);
        end
    end

    assign fetch_count = fc_q;
`endif

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign op        = opcode_of(ir_q);
    assign pc_plus4  = pp4_q;
    assign ir_valid  = valid_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed steps push expectations, a monitor checks them.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        stall_pm;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] ir;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    logic        hlt_en   = 1'b0;
    logic [31:0] hlt_addr = 32'h0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pp4;
        logic        v;
        logic        h;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          nstep  = 0;
    logic [31:0] exp_fc = 32'h0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .stall_pm    (stall_pm),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .ir          (ir),
        .op          (op),
        .pc_plus4    (pc_plus4),
        .ir_valid    (ir_valid),
        .halted      (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    // Instruction memory: address-derived words, optionally one HLT word.
    always_comb begin
        if (hlt_en && imem_addr == hlt_addr) imem_rdata = 32'h4400_0000;
        else                                 imem_rdata = {6'h01, imem_addr[25:0]};
    end

    function automatic logic [31:0] m(input logic [31:0] a);
        return {6'h01, a[25:0]};
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, id, got, exp);
        end
    endtask

    // Monitor: one expected record per clock edge, checked 2 time units after the edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc",       e.id, imem_addr, e.pc);
            chk("ir",       e.id, ir,        e.ir);
            chk("op",       e.id, {26'h0, op}, {26'h0, e.ir[31:26]});
            chk("pc_plus4", e.id, pc_plus4,  e.pp4);
            chk("ir_valid", e.id, {31'h0, ir_valid}, {31'h0, e.v});
            chk("halted",   e.id, {31'h0, halted},   {31'h0, e.h});
`ifdef FETCH_COUNT_EN
            chk("fetch_count", e.id, fetch_count, e.fc);
`endif
        end
    end

    task automatic step(input logic r, input logic st, input logic spm, input logic je,
                        input logic [31:0] tgt, input logic [31:0] epc, input logic [31:0] eir,
                        input logic ev, input logic eh, input logic [31:0] epp4);
        exp_t e;
        reset       = r;
        stall       = st;
        stall_pm    = spm;
        jump_en     = je;
        jump_target = tgt;
        if (!r) exp_fc = 32'h0;
        else if (!spm && ev && !eh) exp_fc = exp_fc + 32'h1;
        e.id  = nstep;
        e.pc  = epc;
        e.ir  = eir;
        e.pp4 = epp4;
        e.v   = ev;
        e.h   = eh;
        e.fc  = exp_fc;
        sb.push_back(e);
        nstep++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic free(input logic [31:0] epc, input logic [31:0] eir, input logic [31:0] epp4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, epc, eir, 1'b1, 1'b0, epp4);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Free running from reset.
        free(32'h4,  m(32'h0), 32'h4);
        free(32'h8,  m(32'h4), 32'h8);
        free(32'hC,  m(32'h8), 32'hC);
        free(32'h10, m(32'hC), 32'h10);

        // Stall at pc=8, then one stall_pm cycle.
        do_reset();
        free(32'h4, m(32'h0), 32'h4);
        free(32'h8, m(32'h4), 32'h8);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8,  m(32'h8), 1'b1, 1'b0, 32'hC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC,  m(32'h8), 1'b1, 1'b0, 32'hC);
        free(32'h10, m(32'hC), 32'h10);

        // Jump with simultaneous stall, unaligned target.
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0043, 32'h40, 32'h0, 1'b0, 1'b0, 32'h10);
        free(32'h44, m(32'h40), 32'h44);
        free(32'h48, m(32'h44), 32'h48);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h48);
        free(32'h0, 32'h07FF_FFFC, 32'h0);
        free(32'h4, m(32'h0), 32'h4);

        // HLT fetched from address 8; jump in the HLT cycle is dropped.
        hlt_addr = 32'h8;
        hlt_en   = 1'b1;
        free(32'h8, m(32'h4), 32'h8);
        free(32'hC, 32'h4400_0000, 32'hC);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'hC, 32'h4400_0000, 1'b1, 1'b1, 32'hC);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i[0], i[1], 1'b1, 32'h200, 32'hC, 32'h4400_0000, 1'b1, 1'b1, 32'hC);
        end
        do_reset();
        hlt_en = 1'b0;
        free(32'h4, m(32'h0), 32'h4);

        // Fetch counting: 5 loads, 2 stall_pm cycles, 1 squash.
        do_reset();
        free(32'h4, m(32'h0), 32'h4);
        free(32'h8, m(32'h4), 32'h8);
        free(32'hC, m(32'h8), 32'hC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, m(32'h8), 1'b1, 1'b0, 32'hC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h14, m(32'h8), 1'b1, 1'b0, 32'hC);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,  32'h0,    1'b0, 1'b0, 32'hC);
        free(32'h4, m(32'h0), 32'h4);
        free(32'h8, m(32'h4), 32'h8);

        repeat (4) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
`ifdef FETCH_COUNT_EN
        chk("fetch_count_final", nstep, fetch_count, 32'd5);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
